// File: rtl/amber48_pipe_ctrl.sv
// Purpose: decode/execute sequencing for amber48 - register scoreboard, branch flush, trap drain.
// Latency: issue/stall/flush/redirect are combinational; scoreboard and FSM update on the next edge.
// Backpressure: decode is held (stall_o) on RAW/WAW hazards, during flush, and outside RUN.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   id_*                           decode-stage instruction fields; id_issue_o/stall_o report the outcome
//   ex_*                           execute-stage result, branch and trap inputs
//   wb_*                           writeback retirement, clears scoreboard entries
//   flush_o, redirect_*            fetch/decode kill and new fetch PC
//   trap_cause_o, trap_epc_o       cause and PC of the most recent trap
//   busy_o                         controller is draining or vectoring
//   stall_cnt_o                    saturating count of stalled decode cycles

package amber48_pipe_ctrl_pkg;
  typedef enum logic [2:0] {
    TRAP_NONE     = 3'd0,
    TRAP_ILLEGAL  = 3'd1,
    TRAP_ECALL    = 3'd2,
    TRAP_EBREAK   = 3'd3,
    TRAP_MISALIGN = 3'd4,
    TRAP_ACCESS   = 3'd5
  } amber48_trap_e;
endpackage

module amber48_pipe_ctrl
  import amber48_pipe_ctrl_pkg::*;
#(
  parameter int                XLEN           = 48,
  parameter int                REG_COUNT      = 16,
  parameter int                REG_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter logic [XLEN-1:0]   TRAP_VECTOR    = 48'h0,
  parameter int                CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_i,
  input  logic                      id_uses_rs2_i,
  input  logic                      id_writes_rd_i,
  output logic                      id_issue_o,
  output logic                      stall_o,
  input  logic                      ex_valid_i,
  input  logic [XLEN-1:0]           ex_pc_i,
  input  logic                      ex_branch_taken_i,
  input  logic [XLEN-1:0]           ex_branch_target_i,
  input  logic                      ex_trap_i,
  input  amber48_trap_e             ex_trap_cause_i,
  input  logic                      wb_valid_i,
  input  logic                      wb_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  output logic                      flush_o,
  output logic                      redirect_valid_o,
  output logic [XLEN-1:0]           redirect_pc_o,
  output amber48_trap_e             trap_cause_o,
  output logic [XLEN-1:0]           trap_epc_o,
  output logic                      busy_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_VECTOR = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [REG_COUNT-1:0]  pending_q;
  logic [REG_COUNT-1:0]  set_mask, clr_mask;
  logic                  hazard;
  logic                  trap_take;
  amber48_trap_e         cause_q;
  logic [XLEN-1:0]       epc_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // Registered scoreboard only: a writeback in this cycle does not unblock
  // a dependent instruction until the following cycle.
  assign hazard = pending_q[id_rs1_i]
                | (id_uses_rs2_i  & pending_q[id_rs2_i])
                | (id_writes_rd_i & pending_q[id_rd_i]);

  assign id_issue_o = id_valid_i & ~hazard & (state_q == ST_RUN) & ~flush_o;
  assign stall_o    = id_valid_i & ~id_issue_o;
  assign busy_o     = (state_q != ST_RUN);

  assign trap_cause_o = cause_q;
  assign trap_epc_o   = epc_q;
  assign stall_cnt_o  = cnt_q;

  always_comb begin
    state_d          = state_q;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    trap_take        = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Trap outranks a taken branch from the same instruction.
        if (ex_valid_i && ex_trap_i) begin
          flush_o   = 1'b1;
          trap_take = 1'b1;
          state_d   = ST_DRAIN;
        end else if (ex_valid_i && ex_branch_taken_i) begin
          flush_o          = 1'b1;
          redirect_valid_o = 1'b1;
          redirect_pc_o    = ex_branch_target_i;
        end
      end
      ST_DRAIN: begin
        // Wait for every older write to retire; the trapping instruction's
        // own rd was never marked because issue is blocked behind it.
        flush_o = 1'b1;
        if (pending_q == '0) begin
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        flush_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = TRAP_VECTOR;
        state_d          = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (id_issue_o && id_writes_rd_i && (id_rd_i != '0)) begin
      set_mask[id_rd_i] = 1'b1;
    end
    if (wb_valid_i && wb_we_i) begin
      clr_mask[wb_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      pending_q <= '0;
      cause_q   <= TRAP_NONE;
      epc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      // Set is applied after clear so a new writer wins over a retiring one.
      pending_q <= (pending_q & ~clr_mask) | set_mask;
      if (trap_take) begin
        cause_q <= ex_trap_cause_i;
        epc_q   <= ex_pc_i;
      end
      if (stall_o && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_amber48_pipe_ctrl.sv
// Purpose: directed scoreboard bench for amber48_pipe_ctrl.
// Latency: expected outputs are queued per cycle and checked on the falling edge.
// Backpressure: none; the bench drives one vector per cycle.

module tb_amber48_pipe_ctrl;
  import amber48_pipe_ctrl_pkg::*;

  localparam int                XLEN  = 48;
  localparam int                RAW   = 4;
  localparam int                CW    = 4;
  localparam logic [XLEN-1:0]   TVEC  = 48'h200;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid_i;
  logic [RAW-1:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic            id_uses_rs2_i, id_writes_rd_i;
  logic            id_issue_o, stall_o;
  logic            ex_valid_i;
  logic [XLEN-1:0] ex_pc_i;
  logic            ex_branch_taken_i;
  logic [XLEN-1:0] ex_branch_target_i;
  logic            ex_trap_i;
  amber48_trap_e   ex_trap_cause_i;
  logic            wb_valid_i, wb_we_i;
  logic [RAW-1:0]  wb_rd_i;
  logic            flush_o, redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;
  amber48_trap_e   trap_cause_o;
  logic [XLEN-1:0] trap_epc_o;
  logic            busy_o;
  logic [CW-1:0]   stall_cnt_o;

  amber48_pipe_ctrl #(
    .XLEN(XLEN), .REG_COUNT(16), .REG_ADDR_WIDTH(RAW),
    .TRAP_VECTOR(TVEC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_uses_rs2_i(id_uses_rs2_i), .id_writes_rd_i(id_writes_rd_i),
    .id_issue_o(id_issue_o), .stall_o(stall_o),
    .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i), .ex_branch_taken_i(ex_branch_taken_i),
    .ex_branch_target_i(ex_branch_target_i), .ex_trap_i(ex_trap_i),
    .ex_trap_cause_i(ex_trap_cause_i),
    .wb_valid_i(wb_valid_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
    .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o),
    .busy_o(busy_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            issue, stall, flush, rv;
    logic [XLEN-1:0] rpc;
    logic            busy;
    logic [CW-1:0]   cnt;
    logic [2:0]      cause;
    logic [XLEN-1:0] epc;
  } exp_t;

  exp_t            exp_q[$];
  logic [XLEN-1:0] redir_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [2:0]      cur_cause = 3'd0;
  logic [XLEN-1:0] cur_epc   = '0;

  // Per-cycle output monitor: compares the full output vector against the
  // record queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [XLEN*2+CW+9-1:0] act, req;
      e   = exp_q.pop_front();
      act = {id_issue_o, stall_o, flush_o, redirect_valid_o, redirect_pc_o,
             busy_o, stall_cnt_o, 3'(trap_cause_o), trap_epc_o};
      req = {e.issue, e.stall, e.flush, e.rv, e.rpc, e.busy, e.cnt, e.cause, e.epc};
      n_tests++;
      if (act !== req) begin
        n_fail++;
        $display("FAIL %s: got iss=%b stl=%b fl=%b rv=%b rpc=%h busy=%b cnt=%0d cause=%0d epc=%h, need iss=%b stl=%b fl=%b rv=%b rpc=%h busy=%b cnt=%0d cause=%0d epc=%h",
                 e.name, id_issue_o, stall_o, flush_o, redirect_valid_o, redirect_pc_o,
                 busy_o, stall_cnt_o, trap_cause_o, trap_epc_o,
                 e.issue, e.stall, e.flush, e.rv, e.rpc, e.busy, e.cnt, e.cause, e.epc);
      end
    end
  end

  // Redirect monitor: every redirect the DUT presents must match the next
  // expected target, and no unexpected redirect may appear.
  always @(negedge clk) begin
    if (redirect_valid_o === 1'b1) begin
      n_tests++;
      if (redir_q.size() == 0) begin
        n_fail++;
        $display("FAIL redirect_unexpected: got pc=%h, need no redirect", redirect_pc_o);
      end else begin
        logic [XLEN-1:0] want;
        want = redir_q.pop_front();
        if (redirect_pc_o !== want) begin
          n_fail++;
          $display("FAIL redirect_pc: got %h, need %h", redirect_pc_o, want);
        end
      end
    end
  end

  task automatic idle();
    id_valid_i = 0; id_rs1_i = '0; id_rs2_i = '0; id_rd_i = '0;
    id_uses_rs2_i = 0; id_writes_rd_i = 0;
    ex_valid_i = 0; ex_pc_i = '0; ex_branch_taken_i = 0; ex_branch_target_i = '0;
    ex_trap_i = 0; ex_trap_cause_i = TRAP_NONE;
    wb_valid_i = 0; wb_we_i = 0; wb_rd_i = '0;
  endtask

  task automatic set_id(input int rs1, input int rs2, input int rd,
                        input bit u2, input bit wr);
    id_valid_i = 1; id_rs1_i = RAW'(rs1); id_rs2_i = RAW'(rs2); id_rd_i = RAW'(rd);
    id_uses_rs2_i = u2; id_writes_rd_i = wr;
  endtask

  task automatic set_ex(input logic [XLEN-1:0] pc, input bit tk, input logic [XLEN-1:0] tgt,
                        input bit tr, input amber48_trap_e cause);
    ex_valid_i = 1; ex_pc_i = pc; ex_branch_taken_i = tk; ex_branch_target_i = tgt;
    ex_trap_i = tr; ex_trap_cause_i = cause;
  endtask

  task automatic set_wb(input int rd);
    wb_valid_i = 1; wb_we_i = 1; wb_rd_i = RAW'(rd);
  endtask

  // Queue the expected outputs for the current cycle, then advance one clock.
  task automatic cyc(input string name, input bit issue, input bit stall, input bit flush,
                     input bit rv, input logic [XLEN-1:0] rpc, input bit busy, input int cnt);
    exp_t e;
    e.name = name; e.issue = issue; e.stall = stall; e.flush = flush; e.rv = rv;
    e.rpc = rpc; e.busy = busy; e.cnt = CW'(cnt); e.cause = cur_cause; e.epc = cur_epc;
    exp_q.push_back(e);
    if (rv) redir_q.push_back(rpc);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; idle();
    @(posedge clk); #1;
    cyc("reset", 0, 0, 0, 0, '0, 0, 0);
    rst = 0;

    // RAW hazard on r3, released one cycle after its writeback
    idle(); set_id(1, 2, 3, 1, 1);  cyc("iss_r3",      1, 0, 0, 0, '0, 0, 0);
    idle(); set_id(3, 0, 0, 0, 0);  cyc("raw_stall",   0, 1, 0, 0, '0, 0, 0);
    set_wb(3);                      cyc("raw_wb",      0, 1, 0, 0, '0, 0, 1);
    idle(); set_id(3, 0, 0, 0, 0);  cyc("raw_release", 1, 0, 0, 0, '0, 0, 2);

    // Same-cycle set and clear of r5: set wins
    idle(); set_id(0, 0, 5, 0, 1); set_wb(5); cyc("set_clr_r5", 1, 0, 0, 0, '0, 0, 2);
    idle(); set_id(5, 0, 0, 0, 0);  cyc("set_wins",    0, 1, 0, 0, '0, 0, 2);
    idle(); set_wb(5);              cyc("clr_r5",      0, 0, 0, 0, '0, 0, 3);

    // r0 is never pending
    idle(); set_id(0, 0, 0, 0, 1);  cyc("wr_r0",       1, 0, 0, 0, '0, 0, 3);
    idle(); set_id(0, 0, 0, 1, 0);  cyc("rd_r0",       1, 0, 0, 0, '0, 0, 3);

    // Taken branch: same-cycle flush and redirect, decode blocked
    idle(); set_id(0, 0, 0, 0, 0); set_ex(48'h80, 1, 48'h100, 0, TRAP_NONE);
    cyc("branch", 0, 1, 1, 1, 48'h100, 0, 3);
    idle();                         cyc("post_branch", 0, 0, 0, 0, '0, 0, 4);

    // Trap with r7 pending; r7 retires two cycles after the trap
    idle(); set_id(0, 0, 7, 0, 1);  cyc("iss_r7",      1, 0, 0, 0, '0, 0, 4);
    idle(); set_ex(48'h40, 0, '0, 1, TRAP_ILLEGAL);
    cyc("trap", 0, 0, 1, 0, '0, 0, 4);
    cur_cause = 3'(TRAP_ILLEGAL); cur_epc = 48'h40;
    idle(); set_id(0, 0, 0, 0, 0);  cyc("drain1",      0, 1, 1, 0, '0, 1, 4);
    idle(); set_wb(7);              cyc("drain2",      0, 0, 1, 0, '0, 1, 5);
    idle();                         cyc("drain3",      0, 0, 1, 0, '0, 1, 5);
    idle();                         cyc("vector",      0, 0, 1, 1, TVEC, 1, 5);
    idle();                         cyc("post_vec",    0, 0, 0, 0, '0, 0, 5);

    // Trap and branch together; second trap while draining is ignored
    idle(); set_ex(48'h80, 1, 48'h300, 1, TRAP_ECALL);
    cyc("trap_br", 0, 0, 1, 0, '0, 0, 5);
    cur_cause = 3'(TRAP_ECALL); cur_epc = 48'h80;
    idle(); set_ex(48'h999, 1, 48'h500, 1, TRAP_ILLEGAL);
    cyc("drain_trap2", 0, 0, 1, 0, '0, 1, 5);
    idle();                         cyc("vec2",        0, 0, 1, 1, TVEC, 1, 5);
    idle();                         cyc("post_vec2",   0, 0, 0, 0, '0, 0, 5);

    // Reset while draining with r9 pending
    idle(); set_id(0, 0, 9, 0, 1);  cyc("iss_r9",      1, 0, 0, 0, '0, 0, 5);
    idle(); set_ex(48'h60, 0, '0, 1, TRAP_EBREAK);
    cyc("trap3", 0, 0, 1, 0, '0, 0, 5);
    cur_cause = 3'(TRAP_EBREAK); cur_epc = 48'h60;
    idle(); rst = 1;                cyc("drain_rst",   0, 0, 1, 0, '0, 1, 5);
    rst = 0; cur_cause = 3'(TRAP_NONE); cur_epc = '0;
    idle(); set_id(9, 0, 0, 0, 0);  cyc("post_rst",    1, 0, 0, 0, '0, 0, 0);
    idle(); set_wb(9);              cyc("wb_after_rst",0, 0, 0, 0, '0, 0, 0);

    // Stall counter saturation at all-ones
    idle(); set_id(0, 0, 4, 0, 1);  cyc("iss_r4",      1, 0, 0, 0, '0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      idle(); set_id(4, 0, 0, 0, 0);
      cyc($sformatf("sat%0d", i), 0, 1, 0, 0, '0, 0, (i > 15) ? 15 : i);
    end
    idle(); set_wb(4);              cyc("sat_hold",    0, 0, 0, 0, '0, 0, 15);
    idle(); set_id(4, 0, 0, 0, 0);  cyc("sat_release", 1, 0, 0, 0, '0, 0, 15);

    idle();
    @(negedge clk); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL exp_drain: got %0d unchecked records, need 0", exp_q.size());
    end
    n_tests++;
    if (redir_q.size() != 0) begin
      n_fail++;
      $display("FAIL redirect_missing: got %0d unseen redirects, need 0", redir_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
